// File: rtl/sram_image_blitter.sv
// Rectangle blit engine: takes greyscale pixels from an Avalon-MM slave FIFO and writes them,
// zoomed by an integer factor and clipped to the frame, to an SRAM frame store as paced single writes.
module sram_image_blitter #(
  parameter int H_RES      = 800,
  parameter int V_RES      = 480,
  parameter int FIFO_DEPTH = 16,
  parameter int GAP        = 3
) (
  input  logic        csi_clk,
  input  logic        csi_reset_n,
  input  logic        avs_chipselect,
  input  logic [2:0]  avs_address,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic        avs_waitrequest,
  output logic        avm_chipselect,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, EMIT, GAPW} state_t;
  state_t state;

  // Slave handshake: a PIXEL write completes on any edge where avs_waitrequest is low;
  // waitrequest rises only for a PIXEL write into a full FIFO that is not popped that cycle.
  logic reg_wr, start_cmd, abort_cmd, pix_wr;
  assign reg_wr    = avs_chipselect && avs_write;
  assign start_cmd = reg_wr && (avs_address == 3'd0) && avs_writedata[0];
  assign abort_cmd = reg_wr && (avs_address == 3'd0) && avs_writedata[1];
  assign pix_wr    = reg_wr && (avs_address == 3'd6);

  logic unused_wdata;
  assign unused_wdata = ^avs_writedata[31:10];

  logic [9:0] x0, w;
  logic [8:0] y0, h;
  logic [2:0] scale;

  logic [9:0] cx0, cw, sx;
  logic [8:0] cy0, ch, sy;
  logic [2:0] cs, i, j;
  logic [7:0] g;
  logic [7:0] gap_cnt;
  logic       done;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;

  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign empty = (count == '0);

  logic last_i, last_j, last_sx, last_sy, blk_last, last_pix, gap_done;
  assign last_i   = (i == cs - 3'd1);
  assign last_j   = (j == cs - 3'd1);
  assign last_sx  = (sx == cw - 10'd1);
  assign last_sy  = (sy == ch - 9'd1);
  assign blk_last = last_i && last_j;
  assign last_pix = last_sx && last_sy;
  assign gap_done = (gap_cnt == 8'(GAP - 2));

  always_comb begin
    pop = 1'b0;
    if (!abort_cmd) begin
      case (state)
        FETCH:   pop = (cw != '0) && (ch != '0) && !empty;
        GAPW:    pop = gap_done && blk_last && !last_pix && !empty;
        default: pop = 1'b0;
      endcase
    end
  end

  assign push            = pix_wr && (!full || pop);
  assign avs_waitrequest = pix_wr && full && !pop;

  // Intermediates are wide enough that sx*S + X0 can never wrap before the clip test.
  logic [13:0] dx;
  logic [12:0] dy;
  logic [19:0] addr;
  logic        in_range;
  always_comb begin
    dx       = 14'(cx0) + 14'(sx) * 14'(cs) + 14'(i);
    dy       = 13'(cy0) + 13'(sy) * 13'(cs) + 13'(j);
    addr     = 20'(dy) * 20'(H_RES) + 20'(dx);
    in_range = (dx < 14'(H_RES)) && (dy < 13'(V_RES));
  end

  logic [2:0] ni, nj;
  logic [9:0] nsx;
  logic [8:0] nsy;
  always_comb begin
    ni  = last_i ? 3'd0 : i + 3'd1;
    nj  = last_i ? (last_j ? 3'd0 : j + 3'd1) : j;
    nsx = blk_last ? (last_sx ? 10'd0 : sx + 10'd1) : sx;
    nsy = (blk_last && last_sx) ? (last_sy ? 9'd0 : sy + 9'd1) : sy;
  end

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      x0    <= '0;
      y0    <= '0;
      w     <= '0;
      h     <= '0;
      scale <= '0;
    end else if (reg_wr) begin
      case (avs_address)
        3'd1:    x0    <= avs_writedata[9:0];
        3'd2:    y0    <= avs_writedata[8:0];
        3'd3:    w     <= avs_writedata[9:0];
        3'd4:    h     <= avs_writedata[8:0];
        3'd5:    scale <= avs_writedata[2:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      avs_readdata <= '0;
    end else if (avs_chipselect && avs_read) begin
      case (avs_address)
        3'd0:    avs_readdata <= {16'b0, 8'(count), 5'b0, done, (state != IDLE), full};
        3'd1:    avs_readdata <= {22'b0, x0};
        3'd2:    avs_readdata <= {23'b0, y0};
        3'd3:    avs_readdata <= {22'b0, w};
        3'd4:    avs_readdata <= {23'b0, h};
        3'd5:    avs_readdata <= {29'b0, scale};
        default: avs_readdata <= '0;
      endcase
    end else begin
      avs_readdata <= '0;
    end
  end

  always_ff @(posedge csi_clk) begin
    if (push) mem[wr_ptr] <= avs_writedata[7:0];
  end

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (abort_cmd) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      state         <= IDLE;
      avm_write     <= 1'b0;
      avm_writedata <= '0;
      done          <= 1'b0;
      cx0 <= '0; cy0 <= '0; cw <= '0; ch <= '0; cs <= 3'd1;
      sx  <= '0; sy  <= '0; i  <= '0; j  <= '0;
      g       <= '0;
      gap_cnt <= '0;
    end else begin
      avm_write <= 1'b0;
      if (abort_cmd) begin
        state <= IDLE;
        done  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start_cmd) begin
            cx0 <= x0; cy0 <= y0; cw <= w; ch <= h;
            cs  <= (scale == 3'd0) ? 3'd1 : scale;
            sx  <= '0; sy <= '0; i <= '0; j <= '0;
            done  <= 1'b0;
            state <= FETCH;
          end
          FETCH: begin
            if ((cw == '0) || (ch == '0)) begin
              done  <= 1'b1;
              state <= IDLE;
            end else if (pop) begin
              g     <= mem[rd_ptr];
              state <= EMIT;
            end
          end
          EMIT: begin
            if (in_range) begin
              avm_write     <= 1'b1;
              avm_writedata <= {addr, 4'b0, g};
              gap_cnt       <= '0;
              state         <= GAPW;
            end else begin
              i <= ni; j <= nj; sx <= nsx; sy <= nsy;
              if (blk_last && last_pix) begin
                done  <= 1'b1;
                state <= IDLE;
              end else if (blk_last) begin
                state <= FETCH;
              end
            end
          end
          GAPW: begin
            if (!gap_done) begin
              gap_cnt <= gap_cnt + 8'd1;
            end else begin
              i <= ni; j <= nj; sx <= nsx; sy <= nsy;
              if (!blk_last) begin
                state <= EMIT;
              end else if (last_pix) begin
                done  <= 1'b1;
                state <= IDLE;
              end else if (pop) begin
                // Fetch the next pixel here so cross-pixel writes keep the same GAP spacing.
                g     <= mem[rd_ptr];
                state <= EMIT;
              end else begin
                state <= FETCH;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign avm_chipselect = avm_write;
  assign dbg_state      = state;

endmodule

// File: tb/tb_sram_image_blitter.sv
// Directed bench for sram_image_blitter: register access, zoomed blits, clipping, FIFO
// back-pressure, abort and reset mid-blit, with expected writes held in exp_q.
module tb_sram_image_blitter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        avs_chipselect, avs_read, avs_write;
  logic [2:0]  avs_address;
  logic [31:0] avs_writedata, avs_readdata;
  logic        avs_waitrequest, avm_chipselect, avm_write;
  logic [31:0] avm_writedata;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] got_q[$];
  int          got_t[$];
  logic [31:0] exp_q[$];

  sram_image_blitter dut (
    .csi_clk(clk), .csi_reset_n(rst_n),
    .avs_chipselect(avs_chipselect), .avs_address(avs_address), .avs_read(avs_read),
    .avs_readdata(avs_readdata), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_waitrequest(avs_waitrequest), .avm_chipselect(avm_chipselect),
    .avm_write(avm_write), .avm_writedata(avm_writedata), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // write monitor
  always @(negedge clk) begin
    if (avm_write) begin
      got_q.push_back(avm_writedata);
      got_t.push_back(cyc);
    end
    checks++;
    if (avm_chipselect !== avm_write) begin
      errors++;
      $display("FAIL avm_chipselect got=%b expected=%b", avm_chipselect, avm_write);
    end
  end

  // driver tasks
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    int n;
    @(negedge clk);
    avs_chipselect = 1; avs_write = 1; avs_address = a; avs_writedata = d;
    #1;
    n = 0;
    while (avs_waitrequest && n < 500) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 500) begin
      errors++;
      $display("FAIL bus_write_stall addr=%0d waitrequest=1 expected=0", a);
    end
    @(posedge clk); #1;
    avs_chipselect = 0; avs_write = 0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    avs_chipselect = 1; avs_read = 1; avs_address = a;
    @(posedge clk); #1;
    avs_chipselect = 0; avs_read = 0;
    d = avs_readdata;
  endtask

  task automatic wait_idle(output bit to);
    logic [31:0] s;
    to = 1;
    for (int n = 0; n < 400; n++) begin
      bus_read(3'd0, s);
      if (!s[1]) begin to = 0; break; end
    end
  endtask

  task automatic set_geom(input int x, input int y, input int ww, input int hh, input int s);
    bus_write(3'd1, 32'(x));
    bus_write(3'd2, 32'(y));
    bus_write(3'd3, 32'(ww));
    bus_write(3'd4, 32'(hh));
    bus_write(3'd5, 32'(s));
  endtask

  task automatic test_reset;
    logic [31:0] s;
    checks++;
    if (avm_write !== 1'b0 || avm_writedata !== 32'h0 || avs_readdata !== 32'h0 || avs_waitrequest !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b/%h/%h/%b expected=0/0/0/0", avm_write, avm_writedata, avs_readdata, avs_waitrequest);
    end
    rst_n = 1;
    bus_read(3'd0, s);
    checks++;
    if (s !== 32'h0) begin errors++; $display("FAIL reset_status got=%h expected=00000000", s); end
  endtask

  task automatic test_regs;
    logic [31:0] r;
    bus_write(3'd1, 32'h0000_02AB);
    bus_write(3'd3, 32'hFFFF_FFFF);
    bus_write(3'd4, 32'hFFFF_FFFF);
    bus_write(3'd5, 32'h0000_000D);
    bus_read(3'd1, r);
    checks++; if (r !== 32'h2AB) begin errors++; $display("FAIL reg_x0 got=%h expected=000002ab", r); end
    bus_read(3'd3, r);
    checks++; if (r !== 32'h3FF) begin errors++; $display("FAIL reg_w got=%h expected=000003ff", r); end
    bus_read(3'd4, r);
    checks++; if (r !== 32'h1FF) begin errors++; $display("FAIL reg_h got=%h expected=000001ff", r); end
    bus_read(3'd5, r);
    checks++; if (r !== 32'h5) begin errors++; $display("FAIL reg_scale got=%h expected=00000005", r); end
    bus_read(3'd6, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL reg_pixel_read got=%h expected=00000000", r); end
  endtask

  task automatic test_basic;
    bit to;
    logic [31:0] s;
    got_q.delete(); got_t.delete();
    exp_q = '{32'h0000_0010, 32'h0000_1020};
    set_geom(0, 0, 2, 1, 1);
    bus_write(3'd6, 32'h10);
    bus_write(3'd6, 32'h20);
    bus_write(3'd0, 32'h1);
    wait_idle(to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout busy=1 expected=0"); end
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_count got=%0d expected=%0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL basic_data[%0d] got=%h expected=%h", k, got_q[k], exp_q[k]); end
    end
    if (got_t.size() >= 2) begin
      checks++;
      if (got_t[1] - got_t[0] != 3) begin errors++; $display("FAIL basic_spacing got=%0d expected=3", got_t[1] - got_t[0]); end
    end
    bus_read(3'd0, s);
    checks++; if (s !== 32'h4) begin errors++; $display("FAIL basic_status got=%h expected=00000004", s); end
  endtask

  task automatic test_scale;
    bit to;
    got_q.delete(); got_t.delete();
    exp_q = '{32'h00FA_A0AB, 32'h00FA_B0AB, 32'h012C_A0AB, 32'h012C_B0AB};
    set_geom(10, 5, 1, 1, 2);
    bus_write(3'd6, 32'hAB);
    bus_write(3'd0, 32'h1);
    wait_idle(to);
    checks++; if (to) begin errors++; $display("FAIL scale_timeout busy=1 expected=0"); end
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL scale_count got=%0d expected=%0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL scale_data[%0d] got=%h expected=%h", k, got_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_clip;
    bit to;
    logic [31:0] s;
    got_q.delete(); got_t.delete();
    exp_q = '{32'h0031_F001};
    set_geom(799, 0, 2, 1, 1);
    bus_write(3'd6, 32'h01);
    bus_write(3'd6, 32'h02);
    bus_write(3'd0, 32'h1);
    wait_idle(to);
    checks++; if (to) begin errors++; $display("FAIL clip_timeout busy=1 expected=0"); end
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL clip_count got=%0d expected=1", got_q.size()); end
    if (got_q.size() >= 1) begin
      checks++;
      if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL clip_data got=%h expected=%h", got_q[0], exp_q[0]); end
    end
    bus_read(3'd0, s);
    checks++; if (s !== 32'h4) begin errors++; $display("FAIL clip_status got=%h expected=00000004", s); end
  endtask

  task automatic test_zero_size;
    bit to;
    logic [31:0] s;
    got_q.delete(); got_t.delete();
    set_geom(0, 0, 0, 1, 1);
    bus_write(3'd6, 32'h33);
    bus_write(3'd0, 32'h1);
    wait_idle(to);
    checks++; if (to) begin errors++; $display("FAIL zero_timeout busy=1 expected=0"); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL zero_writes got=%0d expected=0", got_q.size()); end
    bus_read(3'd0, s);
    checks++; if (s !== 32'h104) begin errors++; $display("FAIL zero_status got=%h expected=00000104", s); end
    bus_write(3'd0, 32'h2);
    bus_read(3'd0, s);
    checks++; if (s !== 32'h0) begin errors++; $display("FAIL zero_abort_status got=%h expected=00000000", s); end
  endtask

  task automatic test_backpressure;
    bit to;
    logic [31:0] s;
    got_q.delete(); got_t.delete();
    set_geom(0, 0, 1, 1, 1);
    for (int k = 0; k < 16; k++) bus_write(3'd6, 32'(8'h40 + k));
    bus_read(3'd0, s);
    checks++; if (s !== 32'h1001) begin errors++; $display("FAIL bp_full_status got=%h expected=00001001", s); end
    @(negedge clk);
    avs_chipselect = 1; avs_write = 1; avs_address = 3'd6; avs_writedata = 32'h50;
    #1;
    checks++; if (avs_waitrequest !== 1'b1) begin errors++; $display("FAIL bp_wait_first got=%b expected=1", avs_waitrequest); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (avs_waitrequest !== 1'b1) begin errors++; $display("FAIL bp_wait_held got=%b expected=1", avs_waitrequest); end
    avs_chipselect = 0; avs_write = 0;
    bus_write(3'd0, 32'h1);
    @(negedge clk);
    avs_chipselect = 1; avs_write = 1; avs_address = 3'd6; avs_writedata = 32'h50;
    #1;
    checks++; if (avs_waitrequest !== 1'b0) begin errors++; $display("FAIL bp_wait_on_pop got=%b expected=0", avs_waitrequest); end
    @(posedge clk); #1;
    avs_chipselect = 0; avs_write = 0;
    wait_idle(to);
    checks++; if (to) begin errors++; $display("FAIL bp_timeout busy=1 expected=0"); end
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 32'h40) begin
      errors++; $display("FAIL bp_write got=%0d writes first=%h expected=1 writes 00000040", got_q.size(), (got_q.size() > 0) ? got_q[0] : 32'hx);
    end
    bus_read(3'd0, s);
    checks++; if (s !== 32'h1005) begin errors++; $display("FAIL bp_level_status got=%h expected=00001005", s); end
  endtask

  task automatic test_abort;
    logic [31:0] s;
    int n, snap;
    got_q.delete(); got_t.delete();
    exp_q = '{32'h0000_0041, 32'h0032_0041, 32'h0000_4042};
    set_geom(0, 0, 28, 28, 4);
    bus_write(3'd0, 32'h1);
    n = 0;
    while (got_q.size() < 100 && n < 3000) begin @(negedge clk); n++; end
    checks++; if (n >= 3000) begin errors++; $display("FAIL abort_reach100 got=%0d expected=100", got_q.size()); end
    bus_write(3'd0, 32'h2);
    repeat (2) @(negedge clk);
    snap = got_q.size();
    checks++; if (snap > 102) begin errors++; $display("FAIL abort_stop got=%0d expected<=102", snap); end
    repeat (30) @(negedge clk);
    checks++; if (got_q.size() != snap) begin errors++; $display("FAIL abort_quiet got=%0d expected=%0d", got_q.size(), snap); end
    if (got_q.size() > 16) begin
      checks++; if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL abort_w0 got=%h expected=%h", got_q[0], exp_q[0]); end
      checks++; if (got_q[4] !== exp_q[1]) begin errors++; $display("FAIL abort_w4 got=%h expected=%h", got_q[4], exp_q[1]); end
      checks++; if (got_q[16] !== exp_q[2]) begin errors++; $display("FAIL abort_w16 got=%h expected=%h", got_q[16], exp_q[2]); end
    end
    bus_read(3'd0, s);
    checks++; if (s !== 32'h0) begin errors++; $display("FAIL abort_status got=%h expected=00000000", s); end
  endtask

  task automatic test_reset_mid;
    bit to;
    logic [31:0] s;
    int n;
    got_q.delete(); got_t.delete();
    set_geom(0, 0, 1, 1, 2);
    bus_write(3'd6, 32'h99);
    bus_write(3'd0, 32'h1);
    n = 0;
    while (!avm_write && n < 200) begin @(negedge clk); n++; end
    checks++; if (n >= 200) begin errors++; $display("FAIL mid_first_write got=none expected=write"); end
    #1 rst_n = 0;
    #1;
    checks++;
    if (avm_write !== 1'b0 || avs_readdata !== 32'h0 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL mid_reset got=%b/%h/%0d expected=0/00000000/0", avm_write, avs_readdata, dbg_state);
    end
    @(negedge clk);
    rst_n = 1;
    bus_read(3'd0, s);
    checks++; if (s !== 32'h0) begin errors++; $display("FAIL mid_status got=%h expected=00000000", s); end
    bus_read(3'd1, s);
    checks++; if (s !== 32'h0) begin errors++; $display("FAIL mid_x0 got=%h expected=00000000", s); end
    got_q.delete(); got_t.delete();
    exp_q = '{32'h0032_205A};
    set_geom(2, 1, 1, 1, 0);
    bus_write(3'd6, 32'h5A);
    bus_write(3'd0, 32'h1);
    wait_idle(to);
    checks++; if (to) begin errors++; $display("FAIL fresh_timeout busy=1 expected=0"); end
    checks++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      errors++; $display("FAIL fresh_write got=%0d writes first=%h expected=1 writes %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 32'hx, exp_q[0]);
    end
    bus_read(3'd0, s);
    checks++; if (s !== 32'h4) begin errors++; $display("FAIL fresh_status got=%h expected=00000004", s); end
  endtask

  initial begin
    rst_n = 0;
    avs_chipselect = 0; avs_read = 0; avs_write = 0;
    avs_address = '0; avs_writedata = '0;
    repeat (3) @(negedge clk);
    #1;
    test_reset;
    test_regs;
    test_basic;
    test_scale;
    test_clip;
    test_zero_size;
    test_backpressure;
    test_abort;
    test_reset_mid;
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
